// File: rtl/logic_unit_arbiter_if.sv
// Request/response bundle between the clients and the shared logic unit arbiter.
// The arbiter connects through the slave modport. The clients and the result consumer use master.
interface logic_unit_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [3*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one registered bitwise logic unit among NREQ requesters.
// state | meaning: IDLE = nothing held, may grant | EXEC = compute latched op | RESP = result offered, grant on handshake
module logic_unit_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  logic_unit_arbiter_if.slave   bus,
  output logic                  busy
);
  localparam int IDW = $clog2(NREQ);
  localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ-1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   id_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic             grant_ok;
  logic             gnt_found;
  logic             grant;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW-1:0]   ptr_nxt;
  logic [IDW:0]     cand;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  function automatic logic [WIDTH-1:0] lu_eval(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      3'd0:    r = a & b;
      3'd1:    r = a | b;
      3'd2:    r = a ^ b;
      3'd3:    r = ~(a & b);
      3'd4:    r = ~(a | b);
      3'd5:    r = ~(a ^ b);
      3'd6:    r = ~a;
      default: r = ~b;
    endcase
    return r;
  endfunction

  // Search starts at ptr and wraps modulo NREQ. The first valid requester found wins.
  always_comb begin
    grant_ok  = (state == IDLE) || ((state == RESP) && bus.rsp_ready);
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!gnt_found && bus.req_valid[cand[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IDW-1:0];
      end
    end
    grant = grant_ok && gnt_found;
  end

  always_comb begin
    bus.req_ready = '0;
    if (grant) bus.req_ready[gnt_idx] = 1'b1;
    ptr_nxt = (gnt_idx == LAST_ID) ? '0 : gnt_idx + IDW'(1);
  end

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_op = bus.req_op[3*i +: 3];
        sel_a  = bus.req_a[WIDTH*i +: WIDTH];
        sel_b  = bus.req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      id_q          <= '0;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_data  <= '0;
      busy          <= 1'b0;
    end else begin
      if (grant) begin
        ptr  <= ptr_nxt;
        id_q <= gnt_idx;
        op_q <= sel_op;
        a_q  <= sel_a;
        b_q  <= sel_b;
      end
      case (state)
        IDLE: begin
          if (grant) begin
            state <= EXEC;
            busy  <= 1'b1;
          end
        end
        EXEC: begin
          bus.rsp_data  <= lu_eval(op_q, a_q, b_q);
          bus.rsp_id    <= id_q;
          bus.rsp_valid <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            if (grant) begin
              state <= EXEC;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state         <= IDLE;
          busy          <= 1'b0;
          bus.rsp_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter. It combines a directed op table, hand-written corner sequences
// and randomized traffic, all checked against a transaction-level reference model.
module tb_logic_unit_arbiter;
  localparam int WIDTH = 8;
  localparam int NREQ  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  logic_unit_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  logic_unit_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    int         id;
    logic [7:0] data;
    int         gcyc;
  } exp_t;

  int n_chk  = 0;
  int n_fail = 0;

  logic       rv  [NREQ];
  logic [2:0] rop [NREQ];
  logic [7:0] ra  [NREQ];
  logic [7:0] rb  [NREQ];
  logic       rr;

  exp_t q[$];
  int   mptr = 0;
  int   cyc  = 0;
  int   last_gnt = -1;
  logic [NREQ-1:0] last_rdy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_lu(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    case (o)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return x ^ y;
      3'd3:    return ~(x & y);
      3'd4:    return ~(x | y);
      3'd5:    return ~(x ^ y);
      3'd6:    return ~x;
      default: return ~y;
    endcase
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]             = rv[i];
      bus.req_op[3*i +: 3]         = rop[i];
      bus.req_a[WIDTH*i +: WIDTH]  = ra[i];
      bus.req_b[WIDTH*i +: WIDTH]  = rb[i];
    end
    bus.rsp_ready = rr;
  endtask

  // One clock cycle. Inputs are driven after the falling edge and checked 1 ns later.
  // The model then advances to the state it will be in after the next rising edge.
  task automatic tick();
    int g;
    int c;
    logic exp_rv;
    logic allow;
    logic [NREQ-1:0] exp_rdy;
    drive();
    #1;
    last_gnt = -1;
    exp_rv = 1'b0;
    if (q.size() > 0) exp_rv = (cyc >= q[0].gcyc + 2);
    allow = (q.size() == 0) || (exp_rv && rr);
    g = -1;
    if (allow) begin
      for (int k = 0; k < NREQ; k++) begin
        c = (mptr + k) % NREQ;
        if (g < 0 && rv[c]) g = c;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    last_rdy = bus.req_ready;
    chk("req_ready", bus.req_ready, exp_rdy);
    chk("rsp_valid", bus.rsp_valid, exp_rv);
    chk("busy", busy, q.size() > 0);
    if (exp_rv) begin
      chk("rsp_id", bus.rsp_id, q[0].id);
      chk("rsp_data", bus.rsp_data, q[0].data);
    end
    if (exp_rv && rr) void'(q.pop_front());
    if (g >= 0) begin
      q.push_back('{id: g, data: ref_lu(rop[g], ra[g], rb[g]), gcyc: cyc});
      mptr = (g + 1) % NREQ;
      rv[g] = 1'b0;
      last_gnt = g;
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_grant(input int maxc, output int g);
    g = -1;
    for (int n = 0; n < maxc && g < 0; n++) begin
      tick();
      g = last_gnt;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < NREQ; i++) rv[i] = 1'b0;
    rr = 1'b1;
    repeat (3) tick();
  endtask

  vec_t tv[8];
  int   exp_rr[6] = '{0, 1, 2, 3, 0, 1};
  int   gids[6];
  int   gcy[6];
  int   gi;
  int   g;
  int   ngr;

  initial begin
    tv[0] = '{op: 3'd0, a: 8'hF0, b: 8'h3C, exp: 8'h30};
    tv[1] = '{op: 3'd1, a: 8'hF0, b: 8'h3C, exp: 8'hFC};
    tv[2] = '{op: 3'd2, a: 8'hF0, b: 8'h3C, exp: 8'hCC};
    tv[3] = '{op: 3'd3, a: 8'hF0, b: 8'h3C, exp: 8'hCF};
    tv[4] = '{op: 3'd4, a: 8'hF0, b: 8'h3C, exp: 8'h03};
    tv[5] = '{op: 3'd5, a: 8'hF0, b: 8'h3C, exp: 8'h33};
    tv[6] = '{op: 3'd6, a: 8'hF0, b: 8'h3C, exp: 8'h0F};
    tv[7] = '{op: 3'd7, a: 8'hF0, b: 8'h3C, exp: 8'hC3};

    for (int i = 0; i < NREQ; i++) begin
      rv[i]  = 1'b0;
      rop[i] = 3'(i + 1);
      ra[i]  = 8'(8'h11 * (i + 3));
      rb[i]  = 8'(8'h5A ^ (i * 7));
    end
    rr = 1'b1;
    drive();
    #2;
    chk("reset rsp_valid", bus.rsp_valid, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset rsp_id", bus.rsp_id, 0);
    chk("reset rsp_data", bus.rsp_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Round robin with every requester asserting continuously
    gi = 0;
    for (int n = 0; n < 11; n++) begin
      for (int i = 0; i < NREQ; i++) rv[i] = 1'b1;
      tick();
      if (last_gnt >= 0 && gi < 6) begin
        gids[gi] = last_gnt;
        gcy[gi]  = n;
        gi++;
      end
    end
    chk("rr grant count", gi, 6);
    for (int k = 0; k < 6; k++) chk("rr order", gids[k], exp_rr[k]);
    for (int k = 1; k < 6; k++) chk("rr spacing", gcy[k] - gcy[k-1], 2);
    drain();

    // Fairness skip: ptr is 2 here
    rv[0] = 1'b1; rv[1] = 1'b1;
    wait_grant(4, g); chk("skip first", g, 0);
    wait_grant(4, g); chk("skip second", g, 1);
    drain();
    rv[3] = 1'b1;
    wait_grant(4, g); chk("skip to 3", g, 3);
    drain();
    rv[0] = 1'b1; rv[3] = 1'b1;
    wait_grant(4, g); chk("ptr wrap to 0", g, 0);
    drain();

    // Op sweep on requester 0, back to back
    for (int i = 0; i < 8; i++) begin
      rop[0] = tv[i].op; ra[0] = tv[i].a; rb[0] = tv[i].b; rv[0] = 1'b1;
      tick();
      chk("sweep grant", last_gnt, 0);
      tick();
      chk("sweep valid", bus.rsp_valid, 1'b1);
      chk("sweep data", bus.rsp_data, tv[i].exp);
      chk("sweep id", bus.rsp_id, 0);
    end
    drain();

    // Backpressure holding 0xCC, then handshake plus grant in the same cycle
    rop[0] = 3'd2; ra[0] = 8'hF0; rb[0] = 8'h3C; rv[0] = 1'b1;
    wait_grant(4, g); chk("bp grant 0", g, 0);
    tick();
    rr = 1'b0;
    rv[1] = 1'b1;
    for (int n = 0; n < 5; n++) begin
      chk("bp hold valid", bus.rsp_valid, 1'b1);
      chk("bp hold data", bus.rsp_data, 8'hCC);
      chk("bp hold id", bus.rsp_id, 0);
      tick();
      chk("bp no grant", last_rdy, 0);
    end
    rr = 1'b1;
    tick();
    chk("bp same-cycle grant", last_gnt, 1);
    chk("bp rsp released", bus.rsp_valid, 1'b0);
    drain();

    // Withdrawn request while the unit is blocked
    rv[0] = 1'b1;
    wait_grant(4, g); chk("wd grant 0", g, 0);
    tick();
    rr = 1'b0;
    rv[1] = 1'b1; rv[3] = 1'b1;
    tick(); tick();
    rv[1] = 1'b0;
    tick();
    rr = 1'b1;
    tick();
    chk("wd grant skips 1", last_gnt, 3);
    ngr = 0;
    for (int n = 0; n < 4; n++) begin
      tick();
      if (last_gnt >= 0) ngr++;
    end
    chk("wd no later grant", ngr, 0);

    // Asynchronous reset in EXEC, between clock edges
    rv[2] = 1'b1;
    wait_grant(4, g); chk("rst pre grant", g, 2);
    for (int i = 0; i < NREQ; i++) rv[i] = 1'b0;
    drive();
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst rsp_data", bus.rsp_data, 0);
    chk("rst rsp_id", bus.rsp_id, 0);
    q.delete();
    mptr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    rop[2] = 3'd0; ra[2] = 8'hAA; rb[2] = 8'h0F;
    rv[2] = 1'b1; rv[3] = 1'b1;
    wait_grant(4, g); chk("rst ptr cleared", g, 2);
    tick();
    chk("rst next id", bus.rsp_id, 2);
    chk("rst next data", bus.rsp_data, 8'h0A);
    drain();

    // Randomized traffic against the reference model
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!rv[i] && $urandom_range(0, 2) == 0) begin
          rv[i]  = 1'b1;
          rop[i] = 3'($urandom_range(0, 7));
          ra[i]  = 8'($urandom);
          rb[i]  = 8'($urandom);
        end else if (rv[i] && $urandom_range(0, 15) == 0) begin
          rv[i] = 1'b0;
        end
      end
      rr = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();
    chk("final idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
